// File: rtl/can_pkg.sv
// Shared field codes and field-length constants for the CAN receive path.
package can_pkg;

  // Protocol-control field codes, numbered 0..26 in frame order.
  typedef enum logic [4:0] {
    BUS_IDLE, ID_1, RTR_1, IDE, ID_2, RTR_2, R1, R0, R0_FD, SKIP_FDF,
    BRS, ESI, DLC, DATA, STUFF_COUNT, CRC, CRC_LIM, ACK, ACK_FD_1,
    ACK_FD_2, ACK_LIM, EOF, INTER, ERROR, OVERLOAD, OFF, INTEGRATING
  } can_field_e;

  localparam int ID_1_LEN        = 11;
  localparam int ID_2_LEN        = 18;
  localparam int DLC_LEN         = 4;
  localparam int STUFF_COUNT_LEN = 4;
  localparam int CRC15_LEN       = 15;
  localparam int CRC17_LEN       = 17;
  localparam int CRC21_LEN       = 21;
  localparam int EOF_LEN         = 7;
  localparam int INTER_LEN       = 3;
  localparam int DELIM_LEN       = 8;   // error / overload delimiter
  localparam int SKIP_FDF_LEN    = 11;  // recessive run that ends a skipped FD frame

endpackage

// File: rtl/can_rx_field_sequencer_dlc.sv
// DLC decoder: payload length in bytes and CRC field length.
module can_dlc_decoder
  import can_pkg::*;
(
  input  logic [3:0] dlc,
  input  logic       fdf,
  input  logic       rtr,
  output logic [6:0] data_len,
  output logic [4:0] crc_len
);

  // Classic frames saturate at 8 bytes (remote frames carry none); FD uses the extended table.
  always_comb begin
    data_len = 7'd0;
    if (fdf) begin
      case (dlc)
        4'd9:    data_len = 7'd12;
        4'd10:   data_len = 7'd16;
        4'd11:   data_len = 7'd20;
        4'd12:   data_len = 7'd24;
        4'd13:   data_len = 7'd32;
        4'd14:   data_len = 7'd48;
        4'd15:   data_len = 7'd64;
        default: data_len = {3'b000, dlc};
      endcase
    end else if (!rtr) begin
      data_len = (dlc > 4'd8) ? 7'd8 : {3'b000, dlc};
    end
    if (!fdf)                   crc_len = 5'(CRC15_LEN);
    else if (data_len <= 7'd16) crc_len = 5'(CRC17_LEN);
    else                        crc_len = 5'(CRC21_LEN);
  end

endmodule

// File: rtl/can_rx_field_sequencer.sv
// Receive field sequencer: counts destuffed bits per field, latches frame
// header flags and emits one registered go strobe naming the next field.
module can_rx_field_sequencer
  import can_pkg::*;
#(
  parameter int DATA_CNT_W = 9
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reset_mode_i,
  input  logic                  sample_point_i,
  input  logic                  rx_bit_i,
  input  logic                  stuff_bit_i,
  input  logic                  error_i,
  input  logic                  fd_enable_i,
  input  logic [4:0]            field_i,
  output logic                  go_valid_o,
  output logic [4:0]            go_field_o,
  output logic [DATA_CNT_W-1:0] bit_cnt_o,
  output logic [3:0]            dlc_o,
  output logic [6:0]            data_len_o,
  output logic                  ide_o,
  output logic                  rtr_o,
  output logic                  fdf_o
);

  // One extra bit so 8*64 data bits can be expressed as a length.
  localparam int CW = DATA_CNT_W + 1;

  can_field_e            field, field_q, tgt, fd_tgt;
  logic                  evaluate, chg, in_frame, last, go;
  logic                  ld_rtr, ld_ide, set_fdf, clr_flags, ld_dlc;
  logic [DATA_CNT_W-1:0] cnt_base, cnt_nxt;
  logic [CW-1:0]         len_m1;
  logic [2:0]            dlc_sr;
  logic [3:0]            dlc_new, dec_dlc;
  logic [6:0]            dec_len;
  logic [4:0]            crc_len;

  assign field    = can_field_e'(field_i);
  assign evaluate = sample_point_i && !stuff_bit_i;
  assign in_frame = (field <= INTER);
  // A field change the sequencer did not request restarts the count.
  assign chg      = (field != field_q);
  assign cnt_base = chg ? '0 : bit_cnt_o;
  assign dlc_new  = {dlc_sr, rx_bit_i};
  assign dec_dlc  = (field == DLC) ? dlc_new : dlc_o;
  assign fd_tgt   = fd_enable_i ? R0_FD : SKIP_FDF;
  assign last     = ({1'b0, cnt_base} == len_m1);

  can_dlc_decoder u_dlc (
    .dlc      (dec_dlc),
    .fdf      (fdf_o),
    .rtr      (rtr_o),
    .data_len (dec_len),
    .crc_len  (crc_len)
  );

  // Length (minus one) of the current field; single-bit fields fall to zero.
  always_comb begin
    len_m1 = '0;
    case (field)
      ID_1:                  len_m1 = CW'(ID_1_LEN - 1);
      ID_2:                  len_m1 = CW'(ID_2_LEN - 1);
      DLC:                   len_m1 = CW'(DLC_LEN - 1);
      DATA:                  len_m1 = CW'({data_len_o, 3'b000}) - CW'(1);
      STUFF_COUNT:           len_m1 = CW'(STUFF_COUNT_LEN - 1);
      CRC:                   len_m1 = CW'(crc_len) - CW'(1);
      EOF:                   len_m1 = CW'(EOF_LEN - 1);
      INTER:                 len_m1 = CW'(INTER_LEN - 1);
      ERROR, OVERLOAD:       len_m1 = CW'(DELIM_LEN - 1);
      SKIP_FDF:              len_m1 = CW'(SKIP_FDF_LEN - 1);
      default:               len_m1 = '0;
    endcase
  end

  // Next-field decision and counter update at an evaluated sample.
  always_comb begin
    go        = 1'b0;
    tgt       = BUS_IDLE;
    cnt_nxt   = cnt_base;
    ld_rtr    = 1'b0;
    ld_ide    = 1'b0;
    set_fdf   = 1'b0;
    clr_flags = 1'b0;
    ld_dlc    = 1'b0;
    if (evaluate) begin
      if (error_i && in_frame) begin
        go  = 1'b1;
        tgt = ERROR;
      end else begin
        cnt_nxt = cnt_base + DATA_CNT_W'(1);
        case (field)
          BUS_IDLE: if (!rx_bit_i) begin go = 1'b1; tgt = ID_1; clr_flags = 1'b1; end
          ID_1:     begin go = last; tgt = RTR_1; end
          RTR_1:    begin go = 1'b1; tgt = IDE; ld_rtr = 1'b1; end
          IDE:      begin go = 1'b1; ld_ide = 1'b1; tgt = rx_bit_i ? ID_2 : R0; end
          ID_2:     begin go = last; tgt = RTR_2; end
          RTR_2:    begin go = 1'b1; tgt = R1; ld_rtr = 1'b1; end
          R1: begin
            go = 1'b1;
            if (!rx_bit_i) tgt = R0;
            else begin tgt = fd_tgt; set_fdf = fd_enable_i; end
          end
          R0: begin
            go = 1'b1;
            if (ide_o || !rx_bit_i) tgt = DLC;
            else begin tgt = fd_tgt; set_fdf = fd_enable_i; end
          end
          R0_FD:    begin go = 1'b1; tgt = BRS; end
          BRS:      begin go = 1'b1; tgt = ESI; end
          ESI:      begin go = 1'b1; tgt = DLC; end
          DLC: begin
            go     = last;
            ld_dlc = last;
            if (dec_len != 7'd0) tgt = DATA;
            else if (fdf_o)      tgt = STUFF_COUNT;
            else                 tgt = CRC;
          end
          DATA:        begin go = last; tgt = fdf_o ? STUFF_COUNT : CRC; end
          STUFF_COUNT: begin go = last; tgt = CRC; end
          CRC:         begin go = last; tgt = CRC_LIM; end
          CRC_LIM:     begin go = 1'b1; tgt = fdf_o ? ACK_FD_1 : ACK; end
          ACK_FD_1:    begin go = 1'b1; tgt = ACK_FD_2; end
          ACK_FD_2:    begin go = 1'b1; tgt = ACK_LIM; end
          ACK:         begin go = 1'b1; tgt = ACK_LIM; end
          ACK_LIM:     begin go = 1'b1; tgt = EOF; end
          EOF:         begin go = last; tgt = INTER; end
          INTER: begin
            if (!rx_bit_i) begin
              go = 1'b1;
              if (cnt_base == DATA_CNT_W'(INTER_LEN - 1)) begin
                tgt       = ID_1;
                clr_flags = 1'b1;
              end else begin
                tgt = OVERLOAD;
              end
            end else begin
              go  = last;
              tgt = BUS_IDLE;
            end
          end
          // Only an unbroken recessive run counts toward the delimiter.
          ERROR, OVERLOAD, SKIP_FDF: begin
            if (!rx_bit_i) cnt_nxt = '0;
            else begin go = last; tgt = INTER; end
          end
          default: cnt_nxt = '0;
        endcase
      end
      if (go) cnt_nxt = '0;
    end
  end

  // Registered strobe, counter, latched DLC/length and frame flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      go_valid_o <= 1'b0;
      go_field_o <= '0;
      bit_cnt_o  <= '0;
      dlc_o      <= '0;
      data_len_o <= '0;
      ide_o      <= 1'b0;
      rtr_o      <= 1'b0;
      fdf_o      <= 1'b0;
      dlc_sr     <= '0;
      field_q    <= BUS_IDLE;
    end else if (reset_mode_i) begin
      go_valid_o <= 1'b0;
      go_field_o <= '0;
      bit_cnt_o  <= '0;
      dlc_o      <= '0;
      data_len_o <= '0;
      ide_o      <= 1'b0;
      rtr_o      <= 1'b0;
      fdf_o      <= 1'b0;
      dlc_sr     <= '0;
      field_q    <= BUS_IDLE;
    end else begin
      go_valid_o <= go;
      if (go) go_field_o <= tgt;
      bit_cnt_o <= cnt_nxt;
      field_q   <= field;
      if (clr_flags) begin
        ide_o <= 1'b0;
        rtr_o <= 1'b0;
        fdf_o <= 1'b0;
      end
      if (ld_rtr)  rtr_o <= rx_bit_i;
      if (ld_ide)  ide_o <= rx_bit_i;
      if (set_fdf) fdf_o <= 1'b1;
      if (evaluate && field == DLC) dlc_sr <= dlc_new[2:0];
      if (ld_dlc) begin
        dlc_o      <= dlc_new;
        data_len_o <= dec_len;
      end
    end
  end

endmodule

// File: tb/tb_can_rx_field_sequencer.sv
// Bench for can_rx_field_sequencer: table of field corner cases, directed
// frames and random frames built from a frame-layout model.
module tb_can_rx_field_sequencer;
  import can_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i, reset_mode_i, sample_point_i, rx_bit_i, stuff_bit_i, error_i, fd_enable_i;
  logic [4:0] field_i;
  logic       go_valid_o, ide_o, rtr_o, fdf_o;
  logic [4:0] go_field_o;
  logic [8:0] bit_cnt_o;
  logic [3:0] dlc_o;
  logic [6:0] data_len_o;

  can_rx_field_sequencer #(.DATA_CNT_W(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .reset_mode_i(reset_mode_i),
    .sample_point_i(sample_point_i), .rx_bit_i(rx_bit_i), .stuff_bit_i(stuff_bit_i),
    .error_i(error_i), .fd_enable_i(fd_enable_i), .field_i(field_i),
    .go_valid_o(go_valid_o), .go_field_o(go_field_o), .bit_cnt_o(bit_cnt_o),
    .dlc_o(dlc_o), .data_len_o(data_len_o), .ide_o(ide_o), .rtr_o(rtr_o), .fdf_o(fdf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    can_field_e fld;
    logic       b;
    logic       err;
    logic       last;
    can_field_e nxt;
  } ent_t;

  typedef struct {
    can_field_e  fld;
    int          n;
    logic [31:0] bits;
    logic [31:0] errm;
    logic        exp_go;
    can_field_e  tgt;
  } vec_t;

  int   errs = 0, checks = 0;
  ent_t q[$];
  int   fdlen [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 16, 20, 24, 32, 48, 64};
  vec_t vt [16];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // One sample point, then observe the strobe cycle and the cycle after it.
  task automatic smp(input logic b, input logic st, input logic er,
                     output logic gv, output logic [4:0] gf, output int bc, output logic gv2);
    @(negedge clk_i);
    sample_point_i = 1'b1; rx_bit_i = b; stuff_bit_i = st; error_i = er;
    @(negedge clk_i);
    sample_point_i = 1'b0; stuff_bit_i = 1'b0; error_i = 1'b0; rx_bit_i = 1'b1;
    gv = go_valid_o; gf = go_field_o; bc = int'(bit_cnt_o);
    @(negedge clk_i);
    gv2 = go_valid_o;
  endtask

  // Append a field of n bits; the previous field then ends by going to f.
  task automatic add(input can_field_e f, input int n, input logic [31:0] pat, input bit rnd);
    ent_t e;
    if (q.size() > 0) begin
      q[q.size()-1].last = 1'b1;
      q[q.size()-1].nxt  = f;
    end
    for (int i = 0; i < n; i++) begin
      e.fld = f; e.b = rnd ? 1'($urandom) : pat[i % 32];
      e.err = 1'b0; e.last = 1'b0; e.nxt = BUS_IDLE;
      q.push_back(e);
    end
  endtask

  task automatic close_q(input can_field_e f);
    q[q.size()-1].last = 1'b1;
    q[q.size()-1].nxt  = f;
  endtask

  // Frame layout from header choices; len = -1 for a skipped FD frame.
  task automatic build(input bit ide, input bit rtr, input bit fdf, input bit fd_en,
                       input int dlc, input int pre, output int len);
    logic [3:0] d;
    int         crcl;
    d = 4'(dlc);
    q.delete();
    fd_enable_i = fd_en;
    add(BUS_IDLE, pre + 1, ~(32'd1 << pre), 0);
    add(ID_1, 11, 32'h0, 1);
    add(RTR_1, 1, {31'd0, ide ? 1'b1 : rtr}, 0);
    add(IDE, 1, {31'd0, ide}, 0);
    if (ide) begin
      add(ID_2, 18, 32'h0, 1);
      add(RTR_2, 1, {31'd0, rtr}, 0);
      add(R1, 1, {31'd0, fdf}, 0);
      if (!fdf) add(R0, 1, 32'h0, 1);
    end else begin
      add(R0, 1, {31'd0, fdf}, 0);
    end
    if (fdf && !fd_en) begin
      add(SKIP_FDF, 16, 32'hFFEF, 0);
      add(INTER, 3, 32'h7, 0);
      close_q(BUS_IDLE);
      len = -1;
      return;
    end
    if (fdf) begin
      add(R0_FD, 1, 32'h0, 1);
      add(BRS, 1, 32'h0, 1);
      add(ESI, 1, 32'h0, 1);
    end
    add(DLC, 4, {28'd0, d[0], d[1], d[2], d[3]}, 0);
    len  = fdf ? fdlen[dlc] : (rtr ? 0 : (dlc > 8 ? 8 : dlc));
    crcl = !fdf ? 15 : (len <= 16 ? 17 : 21);
    if (len > 0) add(DATA, 8 * len, 32'h0, 1);
    if (fdf) add(STUFF_COUNT, 4, 32'h0, 1);
    add(CRC, crcl, 32'h0, 1);
    add(CRC_LIM, 1, 32'h1, 0);
    if (fdf) begin
      add(ACK_FD_1, 1, 32'h0, 0);
      add(ACK_FD_2, 1, 32'h0, 0);
    end else begin
      add(ACK, 1, 32'h0, 0);
    end
    add(ACK_LIM, 1, 32'h1, 0);
    add(EOF, 7, 32'h7F, 0);
    add(INTER, 3, 32'h7, 0);
    close_q(BUS_IDLE);
  endtask

  // Drive the queued bits, acting as the protocol FSM, with stray stuff samples.
  task automatic run_q(input string tag);
    logic gv, gv2;
    logic [4:0] gf;
    int bc, k;
    k = 0;
    field_i = q[0].fld;
    repeat (2) @(negedge clk_i);
    foreach (q[i]) begin
      if ($urandom_range(0, 9) == 0) begin
        smp(1'($urandom), 1'b1, 1'($urandom), gv, gf, bc, gv2);
        chk({tag, " stuff go_valid"}, int'(gv), 0);
        chk({tag, " stuff bit_cnt"}, bc, k);
      end
      smp(q[i].b, 1'b0, q[i].err, gv, gf, bc, gv2);
      if (q[i].last) k = 0;
      else if ((q[i].fld inside {ERROR, OVERLOAD, SKIP_FDF}) && !q[i].b) k = 0;
      else k++;
      chk($sformatf("%s go_valid field%0d", tag, int'(q[i].fld)), int'(gv), int'(q[i].last));
      if (q[i].last) begin
        chk($sformatf("%s go_field from %0d", tag, int'(q[i].fld)), int'(gf), int'(q[i].nxt));
        chk({tag, " strobe width"}, int'(gv2), 0);
        field_i = q[i].nxt;
      end
      chk($sformatf("%s bit_cnt field%0d", tag, int'(q[i].fld)), bc, k);
    end
  endtask

  task automatic run_frame(input string tag, input bit ide, input bit rtr, input bit fdf,
                           input bit fd_en, input int dlc);
    int len;
    build(ide, rtr, fdf, fd_en, dlc, $urandom_range(0, 3), len);
    run_q(tag);
    chk({tag, " ide"}, int'(ide_o), int'(ide));
    chk({tag, " rtr"}, int'(rtr_o), int'(rtr));
    chk({tag, " fdf"}, int'(fdf_o), int'(fdf && fd_en));
    if (len >= 0) begin
      chk({tag, " dlc"}, int'(dlc_o), dlc);
      chk({tag, " data_len"}, int'(data_len_o), len);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic gv, gv2;
    logic [4:0] gf;
    int bc, len, d;
    bit lastb;

    vt[0]  = '{INTER,       1,  32'h0,     32'h0,   1'b1, OVERLOAD};
    vt[1]  = '{INTER,       2,  32'h1,     32'h0,   1'b1, OVERLOAD};
    vt[2]  = '{INTER,       3,  32'h3,     32'h0,   1'b1, ID_1};
    vt[3]  = '{INTER,       3,  32'h7,     32'h0,   1'b1, BUS_IDLE};
    vt[4]  = '{ERROR,       14, 32'h3FC0,  32'h0,   1'b1, INTER};
    vt[5]  = '{OVERLOAD,    12, 32'hFF7,   32'h0,   1'b1, INTER};
    vt[6]  = '{SKIP_FDF,    17, 32'h1FFDF, 32'h0,   1'b1, INTER};
    vt[7]  = '{OFF,         10, 32'h2AA,   32'h3FF, 1'b0, BUS_IDLE};
    vt[8]  = '{INTEGRATING, 11, 32'h7FF,   32'h0,   1'b0, BUS_IDLE};
    vt[9]  = '{ERROR,       8,  32'hFF,    32'hFF,  1'b1, INTER};
    vt[10] = '{EOF,         7,  32'h7F,    32'h0,   1'b1, INTER};
    vt[11] = '{STUFF_COUNT, 4,  32'h5,     32'h0,   1'b1, CRC};
    vt[12] = '{ID_2,        3,  32'h0,     32'h4,   1'b1, ERROR};
    vt[13] = '{BUS_IDLE,    3,  32'h3,     32'h0,   1'b1, ID_1};
    vt[14] = '{INTER,       2,  32'h3,     32'h2,   1'b1, ERROR};
    vt[15] = '{ACK_FD_1,    1,  32'h0,     32'h0,   1'b1, ACK_FD_2};

    rst_i = 1'b1; reset_mode_i = 1'b0; sample_point_i = 1'b0; rx_bit_i = 1'b1;
    stuff_bit_i = 1'b0; error_i = 1'b0; fd_enable_i = 1'b1; field_i = 5'd0;
    repeat (3) @(negedge clk_i);
    chk("reset go_valid", int'(go_valid_o), 0);
    chk("reset go_field", int'(go_field_o), 0);
    chk("reset bit_cnt", int'(bit_cnt_o), 0);
    chk("reset dlc", int'(dlc_o), 0);
    chk("reset data_len", int'(data_len_o), 0);
    chk("reset flags", int'({ide_o, rtr_o, fdf_o}), 0);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int r = 0; r < 16; r++) begin
      field_i = vt[r].fld;
      reset_mode_i = 1'b1;
      @(negedge clk_i);
      reset_mode_i = 1'b0;
      @(negedge clk_i);
      for (int i = 0; i < vt[r].n; i++) begin
        smp(vt[r].bits[i], 1'b0, vt[r].errm[i], gv, gf, bc, gv2);
        lastb = (i == vt[r].n - 1);
        chk($sformatf("vec%0d go_valid bit%0d", r, i), int'(gv), int'(lastb && vt[r].exp_go));
        if (lastb && vt[r].exp_go) begin
          chk($sformatf("vec%0d go_field", r), int'(gf), int'(vt[r].tgt));
          chk($sformatf("vec%0d strobe width", r), int'(gv2), 0);
        end
      end
      chk($sformatf("vec%0d bit_cnt", r), bc, 0);
    end

    field_i = BUS_IDLE;
    reset_mode_i = 1'b1;
    @(negedge clk_i);
    reset_mode_i = 1'b0;

    run_frame("base_dlc2", 1'b0, 1'b0, 1'b0, 1'b1, 2);
    run_frame("ext_fd_dlc15", 1'b1, 1'b0, 1'b1, 1'b1, 15);
    run_frame("fd_skip", 1'b0, 1'b0, 1'b1, 1'b0, 5);
    run_frame("ext_fd_skip", 1'b1, 1'b1, 1'b1, 1'b0, 3);
    run_frame("remote", 1'b0, 1'b1, 1'b0, 1'b1, 4);

    // Error at the 5th data bit, then an error flag and delimiter.
    build(1'b0, 1'b0, 1'b0, 1'b1, 2, 0, len);
    d = 0;
    while (q[d].fld != DATA) d++;
    q = q[0:d+4];
    q[q.size()-1].err = 1'b1;
    add(ERROR, 14, 32'h3FC0, 0);
    add(INTER, 3, 32'h7, 0);
    close_q(BUS_IDLE);
    run_q("data_err");

    // reset_mode on the last DLC bit: no strobe, everything cleared.
    build(1'b1, 1'b1, 1'b0, 1'b1, 3, 0, len);
    d = 0;
    while (q[d].fld != DLC) d++;
    q = q[0:d+2];
    run_q("pre_rstm");
    @(negedge clk_i);
    sample_point_i = 1'b1; rx_bit_i = 1'b0; reset_mode_i = 1'b1;
    @(negedge clk_i);
    sample_point_i = 1'b0; rx_bit_i = 1'b1; reset_mode_i = 1'b0;
    chk("rstm go_valid", int'(go_valid_o), 0);
    chk("rstm go_field", int'(go_field_o), 0);
    chk("rstm bit_cnt", int'(bit_cnt_o), 0);
    chk("rstm dlc", int'(dlc_o), 0);
    chk("rstm data_len", int'(data_len_o), 0);
    chk("rstm flags", int'({ide_o, rtr_o, fdf_o}), 0);
    @(negedge clk_i);
    chk("rstm go_valid later", int'(go_valid_o), 0);
    field_i = BUS_IDLE;
    repeat (2) @(negedge clk_i);

    for (int f = 0; f < 10; f++)
      run_frame($sformatf("rnd%0d", f), 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/can_rx_field_sequencer.md
# can_rx_field_sequencer

Bit-level sequencer that drives the receive protocol-control state machine. It counts destuffed bits at each sample point and decodes DLC, IDE, RTR and FDF. Each time the current field completes, it issues exactly one registered "go" strobe naming the next field. It sits between the bit-timing/destuff logic and `can_protocol_control_fsm`, and replaces ad-hoc per-field go-flag logic.

## Interface
Parameters:
- `DATA_CNT_W`, 9: bit counter width; must cover 512 data bits (64 bytes × 8).

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `reset_mode_i` in 1: synchronous clear of all state and outputs while high.
- `sample_point_i` in 1: one-cycle strobe per bit time. Strobes are at least 3 clk apart.
- `rx_bit_i` in 1: sampled bus value, 0 = dominant.
- `stuff_bit_i` in 1: the current sample is a stuff or fixed-stuff bit. It is not counted.
- `error_i` in 1: a bit, stuff, form or CRC error was detected at this sample point.
- `fd_enable_i` in 1: 1 = FD receive, 0 = FD-tolerant (skip FD frames).
- `field_i` in 5: current state of the protocol FSM, as a `can_field_e` code.
- `go_valid_o` out 1: one-cycle strobe.
- `go_field_o` out 5: target field, valid with `go_valid_o`.
- `bit_cnt_o` out `DATA_CNT_W`: bits counted in the current field.
- `dlc_o` out 4: latched DLC.
- `data_len_o` out 7: payload length in bytes.
- `ide_o`, `rtr_o`, `fdf_o` out 1 each: latched frame flags.

## Operation
Evaluation happens only when `sample_point_i` is high and `stuff_bit_i` is low. Stuff samples change nothing.

Priority at an evaluated sample:
1. `error_i` in any frame field (IDLE through EOF, and INTER): issue go ERROR and clear `bit_cnt`. `error_i` is ignored in ERROR, OVERLOAD, OFF and INTEGRATING.
2. Otherwise increment `bit_cnt`. If the field is complete, issue the go strobe below and clear `bit_cnt` to 0.

Field completion (n = bits in the field):
- IDLE: a dominant bit (SOF) goes to ID_1.
- ID_1, n=11 → RTR_1. RTR_1, n=1 → IDE; latch `rtr_o` = bit.
- IDE, n=1: latch `ide_o` = bit. Bit 1 → ID_2; bit 0 → R0.
- ID_2, n=18 → RTR_2. RTR_2, n=1 → R1; latch `rtr_o`.
- R1 (extended FDF position):
  - Bit 0 → R0.
  - Bit 1 and `fd_enable_i` → R0_FD, with `fdf_o`=1.
  - Bit 1 and not `fd_enable_i` → SKIP_FDF.
- R0:
  - If `ide_o`=1 → DLC.
  - Otherwise (base FDF position): bit 0 → DLC; bit 1 → R0_FD or SKIP_FDF, by the same rule as R1.
- R0_FD → BRS → ESI → DLC, 1 bit each.
- DLC, n=4: latch `dlc_o`, then compute `data_len_o`:
  - Classic: min(dlc, 8), forced to 0 if `rtr_o`.
  - FD: 0–8, then 12, 16, 20, 24, 32, 48, 64.
  - Next field: len>0 → DATA; len=0 and fdf → STUFF_COUNT; otherwise CRC.
- DATA, n = 8·len → STUFF_COUNT if fdf, else CRC.
- STUFF_COUNT, n=4 → CRC.
- CRC: n=15 classic, 17 for FD with len≤16, 21 for FD with len>16 → CRC_LIM.
- CRC_LIM, n=1 → ACK_FD_1 if fdf, else ACK.
- ACK_FD_1 → ACK_FD_2 → ACK_LIM, 1 bit each. ACK → ACK_LIM. ACK_LIM → EOF.
- EOF, n=7 → INTER.
- INTER, 3 bits:
  - Dominant at bit 1 or 2 → OVERLOAD.
  - Dominant at bit 3 → ID_1.
  - Three recessive bits → IDLE.
- ERROR / OVERLOAD: count only recessive bits; any dominant bit restarts the count. 8 consecutive recessive bits (the delimiter) → INTER.
- SKIP_FDF: 11 consecutive recessive bits → INTER. A dominant bit restarts the count.
- OFF / INTEGRATING: no go strobes; the counter is held at 0.

Latched frame flags clear on the go to ID_1.

## Timing
- Reset (`rst_i` or `reset_mode_i`) drives every output to 0 and clears all counters and flags.
- `go_valid_o` and `go_field_o` are registered. They assert on the cycle after the evaluated sample point, for exactly 1 cycle.
- The FSM updates `field_i` 1 cycle after `go_valid_o`. The next sample point is at least 3 cycles away, so the field is stable before the next evaluation.
- `bit_cnt_o`, `dlc_o`, `data_len_o` and the flags update in the same cycle as the go strobe.
- A change of `field_i` that was not caused by a go strobe (for example an external bus_free) clears `bit_cnt` on the next cycle.
- `reset_mode_i` asserted mid-frame: everything is cleared on the next edge and no go strobe is emitted.

## Structure
- Package `can_pkg` holds:
  - `typedef enum logic [4:0] can_field_e`, with codes 0..26 in this order: BUS_IDLE, ID_1, RTR_1, IDE, ID_2, RTR_2, R1, R0, R0_FD, SKIP_FDF, BRS, ESI, DLC, DATA, STUFF_COUNT, CRC, CRC_LIM, ACK, ACK_FD_1, ACK_FD_2, ACK_LIM, EOF, INTER, ERROR, OVERLOAD, OFF, INTEGRATING.
  - Field-length constants.
- Sub-module `can_dlc_decoder`: combinational DLC/FDF/RTR → `data_len` and CRC length.

## Test plan
- Base classic frame, ID 0x123, DLC 2: go sequence ID_1, RTR_1, IDE, R0, DLC, DATA (16 bits), CRC (15 bits), CRC_LIM, ACK, ACK_LIM, EOF, INTER, IDLE, with `data_len_o`=2.
- Extended FD frame, DLC 0xF, `fd_enable_i`=1:
  - `data_len_o`=64.
  - DATA completes after 512 counted bits.
  - STUFF_COUNT, then CRC of 21 bits, then ACK_FD_1, ACK_FD_2.
  - Stuff samples inside the frame do not advance `bit_cnt_o`.
- FD frame with `fd_enable_i`=0: go SKIP_FDF after R0; a dominant bit restarts the count; go INTER only after 11 consecutive recessive bits.
- `error_i` at DATA bit 5 → go ERROR. Then 6 dominant bits followed by 8 recessive bits → go INTER on the 8th recessive bit.
- INTER: dominant at bit 2 → go OVERLOAD. Dominant at bit 3 → go ID_1. `reset_mode_i` mid-DLC → all outputs 0 and no go strobe.
